// File: rtl/sram_req_adapter.sv
// Request-side adapter for the single-port sram macro: valid/ready requests in,
// bare macro strobes out, read data returned through a small credit-checked FIFO.
module sram_req_adapter #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_WORDS  = 1024,
    parameter int RSP_DEPTH  = 2,
    parameter int INIT_ZERO  = 1,
    localparam int AW = $clog2(NUM_WORDS),
    localparam int BW = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [AW-1:0]         req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [BW-1:0]         req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  init_done_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [AW-1:0]         sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [BW-1:0]         sram_be_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic                  state;
    logic [AW-1:0]         icnt;
    logic                  inflight;
    logic [PW-1:0]         rptr;
    logic [PW-1:0]         wptr;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];

    logic          run;
    logic          initing;
    logic          pop;
    logic          push;
    logic          accept;
    logic          rd_issue;
    logic          rd_ok;
    logic [CW:0]   credit_use;

    // Outputs are forced quiet while reset is held, whatever state we came from.
    assign run     = (state == ST_RUN) && !rst_i;
    assign initing = (state == ST_INIT) && !rst_i;

    assign rsp_valid_o = !rst_i && (count != '0);
    assign rsp_rdata_o = fifo_mem[rptr];
    assign init_done_o = run;

    assign pop  = rsp_valid_o && rsp_ready_i;
    assign push = inflight;

    // A read is only issued if its response is guaranteed a FIFO slot.
    assign credit_use = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign rd_ok      = credit_use < (CW+1)'(RSP_DEPTH);

    assign req_ready_o = run && (req_we_i || rd_ok);
    assign accept      = req_valid_i && req_ready_o;
    assign rd_issue    = accept && !req_we_i;

    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = req_addr_i;
        sram_wdata_o = req_wdata_i;
        sram_be_o    = req_be_i;
        if (initing) begin
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = icnt;
            sram_wdata_o = '0;
            sram_be_o    = '1;
        end else if (run) begin
            sram_req_o = accept;
            sram_we_o  = req_we_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
            icnt  <= '0;
        end else if (state == ST_INIT) begin
            icnt <= icnt + 1'b1;
            if (icnt == AW'(NUM_WORDS - 1)) begin
                state <= ST_RUN;
            end
        end
    end

    // Response FIFO; the macro data lands one cycle after the read strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight <= 1'b0;
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            inflight <= rd_issue;
            if (push) begin
                fifo_mem[wptr] <= sram_rdata_i;
                wptr           <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_sram_req_adapter.sv
// Directed bench for sram_req_adapter with a small behavioural sram model attached.
module tb_sram_req_adapter;

    localparam int DW = 64;
    localparam int NW = 16;
    localparam int RD = 2;
    localparam int AW = 4;
    localparam int BW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic [BW-1:0] req_be_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_rdata_o;
    logic          init_done_o;
    logic          sram_req_o;
    logic          sram_we_o;
    logic [AW-1:0] sram_addr_o;
    logic [DW-1:0] sram_wdata_o;
    logic [BW-1:0] sram_be_o;
    logic [DW-1:0] sram_rdata_i = '0;

    logic          preload = 1'b0;
    logic [DW-1:0] sram_mem [NW];

    int checks = 0;
    int errors = 0;
    int outstanding = 0;

    sram_req_adapter #(
        .DATA_WIDTH(DW),
        .NUM_WORDS (NW),
        .RSP_DEPTH (RD),
        .INIT_ZERO (1)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .init_done_o (init_done_o),
        .sram_req_o  (sram_req_o),
        .sram_we_o   (sram_we_o),
        .sram_addr_o (sram_addr_o),
        .sram_wdata_o(sram_wdata_o),
        .sram_be_o   (sram_be_o),
        .sram_rdata_i(sram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Macro model: byte-masked writes, registered read data; preload fills garbage.
    always @(posedge clk_i) begin
        if (preload) begin
            for (int i = 0; i < NW; i++) begin
                sram_mem[i] <= 64'hA5A5_5A5A_0000_0000 | 64'(i + 1);
            end
        end else if (sram_req_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < BW; b++) begin
                    if (sram_be_o[b]) sram_mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
                end
            end else begin
                sram_rdata_i <= sram_mem[sram_addr_o];
            end
        end
    end

    // Reads accepted but not yet consumed must never exceed the FIFO depth.
    always @(posedge clk_i) begin
        if (rst_i) begin
            outstanding = 0;
        end else begin
            if (rsp_valid_o && rsp_ready_i) outstanding--;
            if (req_valid_i && req_ready_o && !req_we_i) begin
                outstanding++;
                checks++;
                if (outstanding > RD) begin
                    errors++;
                    $display("[TB] FAIL credit: outstanding %0d, limit %0d", outstanding, RD);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
        req_valid_i = v;
        req_we_i    = we;
        req_addr_i  = a;
        req_wdata_i = d;
        req_be_i    = be;
    endtask

    task automatic test_reset();
        logic [DW+AW+BW+3:0] got;
        logic [DW+AW+BW+3:0] exp;
        tick();
        @(negedge clk_i);
        checks++;
        if ({req_ready_o, rsp_valid_o, init_done_o, sram_req_o} !== 4'b0000 || rsp_rdata_o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got rdy/vld/done/req %b%b%b%b rdata %h, expected 0000 rdata 0",
                     req_ready_o, rsp_valid_o, init_done_o, sram_req_o, rsp_rdata_o);
        end
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < NW; i++) begin
            @(negedge clk_i);
            got = {sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o, req_ready_o, init_done_o};
            exp = {1'b1, 1'b1, AW'(i), {DW{1'b0}}, {BW{1'b1}}, 1'b0, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL init_write[%0d]: got %h, expected %h", i, got, exp);
            end
            tick();
        end
        @(negedge clk_i);
        checks++;
        if (init_done_o !== 1'b1 || sram_req_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL init_done: got done %b req %b, expected done 1 req 0", init_done_o, sram_req_o);
        end
        tick();
        drive(1'b1, 1'b0, 4'd5, '0, '0);
        @(negedge clk_i);
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL read5_ready: got %b, expected 1", req_ready_o);
        end
        tick();
        drive(1'b0, 1'b0, '0, '0, '0);
        tick();
        @(negedge clk_i);
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 64'h0) begin
            errors++;
            $display("[TB] FAIL read5_zero: got valid %b data %h, expected valid 1 data 0", rsp_valid_o, rsp_rdata_o);
        end
        tick();
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b1, 4'd3, 64'hDEADBEEF_CAFEF00D, 8'h0F);
        @(negedge clk_i);
        checks++;
        if (req_ready_o !== 1'b1 || sram_req_o !== 1'b1 || sram_we_o !== 1'b1 || sram_be_o !== 8'h0F) begin
            errors++;
            $display("[TB] FAIL wr3_strobe: got rdy %b req %b we %b be %h, expected 1 1 1 0f",
                     req_ready_o, sram_req_o, sram_we_o, sram_be_o);
        end
        tick();
        drive(1'b1, 1'b0, 4'd3, '0, '0);
        @(negedge clk_i);
        checks++;
        if (req_ready_o !== 1'b1 || sram_req_o !== 1'b1 || sram_we_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rd3_strobe: got rdy %b req %b we %b, expected 1 1 0", req_ready_o, sram_req_o, sram_we_o);
        end
        tick();
        drive(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk_i);
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rd3_latency1: got valid %b, expected 0", rsp_valid_o);
        end
        tick();
        @(negedge clk_i);
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 64'h00000000_CAFEF00D) begin
            errors++;
            $display("[TB] FAIL rd3_data: got valid %b data %h, expected valid 1 data 00000000cafef00d",
                     rsp_valid_o, rsp_rdata_o);
        end
        tick();
        @(negedge clk_i);
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rd3_drained: got valid %b, expected 0", rsp_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, AW'(i), 64'h1000 + 64'(i), 8'hFF);
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            if (c < 8) drive(1'b1, 1'b0, AW'(c), '0, '0);
            else       drive(1'b0, 1'b0, '0, '0, '0);
            @(negedge clk_i);
            if (c < 8) begin
                checks++;
                if (req_ready_o !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_ready[%0d]: got %b, expected 1", c, req_ready_o);
                end
            end
            if (c >= 2) begin
                checks++;
                if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 64'h1000 + 64'(c - 2)) begin
                    errors++;
                    $display("[TB] FAIL b2b_rsp[%0d]: got valid %b data %h, expected valid 1 data %h",
                             c - 2, rsp_valid_o, rsp_rdata_o, 64'h1000 + 64'(c - 2));
                end
            end
            tick();
        end
        @(negedge clk_i);
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_extra: got valid %b, expected 0", rsp_valid_o);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] addr [9];
        logic          vld  [9];
        logic          rrdy [9];
        logic          erdy [9];
        logic          erv  [9];
        logic [DW-1:0] edat [9];
        addr = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd0, 4'd0, 4'd0};
        vld  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        rrdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        erdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        erv  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        edat = '{64'h0, 64'h0, 64'h1000, 64'h1000, 64'h1000, 64'h1001, 64'h1002, 64'h1003, 64'h0};
        for (int c = 0; c < 9; c++) begin
            drive(vld[c], 1'b0, addr[c], '0, '0);
            rsp_ready_i = rrdy[c];
            @(negedge clk_i);
            if (vld[c]) begin
                checks++;
                if (req_ready_o !== erdy[c]) begin
                    errors++;
                    $display("[TB] FAIL bp_ready[%0d]: got %b, expected %b", c, req_ready_o, erdy[c]);
                end
            end
            checks++;
            if (rsp_valid_o !== erv[c] || (erv[c] && rsp_rdata_o !== edat[c])) begin
                errors++;
                $display("[TB] FAIL bp_rsp[%0d]: got valid %b data %h, expected valid %b data %h",
                         c, rsp_valid_o, rsp_rdata_o, erv[c], edat[c]);
            end
            tick();
        end
        rsp_ready_i = 1'b1;
    endtask

    task automatic test_alternate();
        logic          vld  [11];
        logic          we   [11];
        logic [DW-1:0] wd   [11];
        logic          rrdy [11];
        logic          erdy [11];
        logic          erv  [11];
        logic [DW-1:0] edat [11];
        vld  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        we   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        wd   = '{64'h1111_0000_0000_00A0, 64'h0, 64'h1111_0000_0000_00A1, 64'h0,
                 64'h1111_0000_0000_00A2, 64'h0, 64'h1111_0000_0000_00A3, 64'h0, 64'h0, 64'h0, 64'h0};
        rrdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        erdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        erv  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        edat = '{64'h0, 64'h0, 64'h0, 64'h1111_0000_0000_00A0, 64'h1111_0000_0000_00A0,
                 64'h1111_0000_0000_00A0, 64'h1111_0000_0000_00A0, 64'h1111_0000_0000_00A0,
                 64'h1111_0000_0000_00A1, 64'h1111_0000_0000_00A3, 64'h0};
        for (int c = 0; c < 11; c++) begin
            drive(vld[c], we[c], 4'd1, wd[c], 8'hFF);
            rsp_ready_i = rrdy[c];
            @(negedge clk_i);
            if (vld[c]) begin
                checks++;
                if (req_ready_o !== erdy[c]) begin
                    errors++;
                    $display("[TB] FAIL alt_ready[%0d]: got %b, expected %b", c, req_ready_o, erdy[c]);
                end
            end
            checks++;
            if (rsp_valid_o !== erv[c] || (erv[c] && rsp_rdata_o !== edat[c])) begin
                errors++;
                $display("[TB] FAIL alt_rsp[%0d]: got valid %b data %h, expected valid %b data %h",
                         c, rsp_valid_o, rsp_rdata_o, erv[c], edat[c]);
            end
            tick();
        end
        rsp_ready_i = 1'b1;
    endtask

    task automatic test_reset_mid();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        @(negedge clk_i);
        checks++;
        if (sram_addr_o !== 4'd7 || sram_req_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_init_addr: got addr %0d req %b, expected addr 7 req 1", sram_addr_o, sram_req_o);
        end
        tick();
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({sram_req_o, req_ready_o, init_done_o, rsp_valid_o} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL mid_init_quiet: got req/rdy/done/vld %b%b%b%b, expected 0000",
                     sram_req_o, req_ready_o, init_done_o, rsp_valid_o);
        end
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < NW; i++) begin
            @(negedge clk_i);
            checks++;
            if (sram_addr_o !== AW'(i) || sram_req_o !== 1'b1 || init_done_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reinit[%0d]: got addr %0d req %b done %b, expected addr %0d req 1 done 0",
                         i, sram_addr_o, sram_req_o, init_done_o, i);
            end
            tick();
        end
        drive(1'b1, 1'b0, 4'd3, '0, '0);
        @(negedge clk_i);
        checks++;
        if (req_ready_o !== 1'b1 || init_done_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrd_accept: got rdy %b done %b, expected 1 1", req_ready_o, init_done_o);
        end
        tick();
        drive(1'b0, 1'b0, '0, '0, '0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < NW + 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (rsp_valid_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL dropped_read[%0d]: got valid %b, expected 0", i, rsp_valid_o);
            end
            tick();
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        rsp_ready_i = 1'b1;
        drive(1'b0, 1'b0, '0, '0, '0);
        preload = 1'b1;
        tick();
        preload = 1'b0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_alternate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
